// File: rtl/tile_rom_addr_gen.sv
// Two-stage tile-type to glyph-ROM row address generator with frame-stepped rotation of the triangle/circle tiles.
// Build option: define TILE_ROM_ADDR_ERR_EN to add the tile-code range check, zero remap and sticky err_o.
module tile_rom_addr_gen #(
    parameter int TILE_TYPE_WIDTH = 7,
    parameter int ROM_ADDR_WIDTH  = 12,
    parameter int TILE_ROWS_LOG2  = 5,
    parameter int NUM_TILE_TYPES  = 109,
    parameter int TRI_BASE        = 3,
    parameter int CIRC_BASE       = 8,
    parameter int ANIM_STEPS      = 5,
    parameter int ANIM_PERIOD     = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    input  logic [TILE_TYPE_WIDTH-1:0] tile_type_i,
    input  logic [TILE_ROWS_LOG2-1:0]  row_i,
    input  logic                       frame_start_i,
    input  logic                       anim_en_i,
    output logic                       valid_o,
    output logic [ROM_ADDR_WIDTH-1:0]  addr_o,
    output logic                       err_o
);
    localparam int PH_W  = (ANIM_STEPS > 1) ? $clog2(ANIM_STEPS) : 1;
    localparam int FC_W  = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam int EFF_W = TILE_TYPE_WIDTH + 1;
    localparam int CAT_W = EFF_W + TILE_ROWS_LOG2;

    localparam logic [TILE_TYPE_WIDTH-1:0] TRI_CODE  = TILE_TYPE_WIDTH'(TRI_BASE);
    localparam logic [TILE_TYPE_WIDTH-1:0] CIRC_CODE = TILE_TYPE_WIDTH'(CIRC_BASE);
    localparam logic [FC_W-1:0]            FC_LAST   = FC_W'(ANIM_PERIOD - 1);
    localparam logic [PH_W-1:0]            PH_LAST   = PH_W'(ANIM_STEPS - 1);

    // Every legal tile code must map into the ROM without address aliasing.
    generate
        if (longint'(NUM_TILE_TYPES) * (longint'(1) << TILE_ROWS_LOG2) > (longint'(1) << ROM_ADDR_WIDTH)) begin : g_bad_rom_size
            $error("tile_rom_addr_gen: NUM_TILE_TYPES rows do not fit in ROM_ADDR_WIDTH");
        end
        if (ANIM_PERIOD < 1 || ANIM_STEPS < 1) begin : g_bad_anim
            $error("tile_rom_addr_gen: ANIM_PERIOD and ANIM_STEPS must be >= 1");
        end
    endgenerate

    logic [FC_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [PH_W-1:0] phase_reg, phase_next;

    // Disabling animation forces the counters to 0, even on a wrapping frame pulse.
    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        phase_next     = phase_reg;
        if (!anim_en_i) begin
            frame_cnt_next = '0;
            phase_next     = '0;
        end else if (frame_start_i) begin
            if (frame_cnt_reg == FC_LAST) begin
                frame_cnt_next = '0;
                phase_next     = (phase_reg == PH_LAST) ? '0 : phase_reg + PH_W'(1);
            end else begin
                frame_cnt_next = frame_cnt_reg + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_reg <= '0;
            phase_reg     <= '0;
        end else begin
            frame_cnt_reg <= frame_cnt_next;
            phase_reg     <= phase_next;
        end
    end

    // Only the base codes rotate; explicit rotation codes pass through untouched.
    logic [EFF_W-1:0] eff_type_next;
    always_comb begin
        eff_type_next = {1'b0, tile_type_i};
        if (tile_type_i == TRI_CODE || tile_type_i == CIRC_CODE) begin
            eff_type_next = {1'b0, tile_type_i} + EFF_W'(phase_reg);
        end
    end

    logic                      s1_valid_reg;
    logic [EFF_W-1:0]          s1_type_reg;
    logic [TILE_ROWS_LOG2-1:0] s1_row_reg;
    logic [CAT_W-1:0]          cat_addr;
    logic [ROM_ADDR_WIDTH-1:0] addr_next;
    logic                      valid_reg;
    logic [ROM_ADDR_WIDTH-1:0] addr_reg;

    assign cat_addr = {s1_type_reg, s1_row_reg};

`ifdef TILE_ROM_ADDR_ERR_EN
    localparam logic [EFF_W-1:0] NUM_TYPES_W = EFF_W'(NUM_TILE_TYPES);

    logic s1_range_reg;
    logic err_reg;

    // Out-of-range codes fall back to row 0 of the empty-window glyph.
    always_comb begin
        addr_next = ROM_ADDR_WIDTH'(cat_addr);
        if (s1_range_reg) begin
            addr_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_range_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            s1_range_reg <= ({1'b0, tile_type_i} >= NUM_TYPES_W);
            err_reg      <= err_reg | (s1_valid_reg & s1_range_reg);
        end
    end

    assign err_o = err_reg;
`else
    always_comb begin
        addr_next = ROM_ADDR_WIDTH'(cat_addr);
    end

    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg <= 1'b0;
            s1_type_reg  <= '0;
            s1_row_reg   <= '0;
            valid_reg    <= 1'b0;
            addr_reg     <= '0;
        end else begin
            s1_valid_reg <= valid_i;
            s1_type_reg  <= eff_type_next;
            s1_row_reg   <= row_i;
            valid_reg    <= s1_valid_reg;
            addr_reg     <= addr_next;
        end
    end

    assign valid_o = valid_reg;
    assign addr_o  = addr_reg;
endmodule

// File: tb/tb_tile_rom_addr_gen.sv
// Randomized and directed bench for tile_rom_addr_gen against an arithmetic reference model.
// Follows TILE_ROM_ADDR_ERR_EN the same way the design does.
module tb_tile_rom_addr_gen;
    localparam int ROWS   = 32;
    localparam int NTYPES = 109;
    localparam int PERIOD = 15;
    localparam int STEPS  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [6:0]  tile_type;
    logic [4:0]  row;
    logic        frame_start;
    logic        anim_en;
    logic        valid_out;
    logic [11:0] addr;
    logic        err;

    int n_vec = 0;
    int n_miscmp = 0;

    // Reference model state: pulses counted since animation was last enabled.
    int pulses;
    int s1_valid, s1_addr, s1_oor;
    int exp_valid, exp_addr, exp_err;

    always #5 clk = ~clk;

    tile_rom_addr_gen dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid_in),
        .tile_type_i   (tile_type),
        .row_i         (row),
        .frame_start_i (frame_start),
        .anim_en_i     (anim_en),
        .valid_o       (valid_out),
        .addr_o        (addr),
        .err_o         (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_addr(input int t, input int r, input int ph);
        int eff;
        int a;
        eff = t;
        if (t == 3 || t == 8) eff = t + ph;
        a = (eff * ROWS + r) % 4096;
`ifdef TILE_ROM_ADDR_ERR_EN
        if (t >= NTYPES) a = 0;
`endif
        return a;
    endfunction

    task automatic model_reset();
        pulses = 0;
        s1_valid = 0; s1_addr = 0; s1_oor = 0;
        exp_valid = 0; exp_addr = 0; exp_err = 0;
    endtask

    // One clock: update the model at the edge, then compare at the falling edge.
    task automatic tick();
        int ph;
        @(posedge clk);
        if (rst_n) begin
            exp_valid = s1_valid;
            exp_addr  = s1_addr;
`ifdef TILE_ROM_ADDR_ERR_EN
            if (s1_valid != 0 && s1_oor != 0) exp_err = 1;
`endif
            ph = (pulses / PERIOD) % STEPS;
            s1_valid = int'(valid_in);
            s1_addr  = model_addr(int'(tile_type), int'(row), ph);
            s1_oor   = (int'(tile_type) >= NTYPES) ? 1 : 0;
            if (!anim_en) pulses = 0;
            else if (frame_start) pulses++;
        end else begin
            model_reset();
        end
        @(negedge clk);
        check_eq("valid_o", valid_out, exp_valid);
        check_eq("addr_o", addr, exp_addr);
        check_eq("err_o", err, exp_err);
        if (valid_out) $display("txn t=%0t addr=%0d err=%0d", $time, addr, err);
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; tile_type = '0; row = '0; frame_start = 1'b0;
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0; frame_start = 1'b1;
            tick();
        end
        frame_start = 1'b0;
    endtask

    // Issue one valid sample, one idle cycle, then check the literal address.
    task automatic issue(input int t, input int r, input int want, input string tag);
        valid_in = 1'b1; tile_type = 7'(t); row = 5'(r); frame_start = 1'b0;
        tick();
        idle_inputs();
        tick();
        check_eq(tag, addr, want);
        check_eq({tag, "_valid"}, valid_out, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; anim_en = 1'b0;
        idle_inputs();
        model_reset();
        tick();
        tick();
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_err", err, 0);
        rst_n = 1'b1;

        // Type 1 row 7, then rows 0..31 back to back.
        valid_in = 1'b1; tile_type = 7'd1; row = 5'd7;
        tick();
        for (int r = 0; r < 32; r++) begin
            row = 5'(r);
            tick();
            if (r == 0) check_eq("t1r7", addr, 39);
            else check_eq("t1_row_seq", addr, 32 + r - 1);
        end
        idle_inputs();
        tick();
        check_eq("t1r31", addr, 63);

        // Static rendering ignores frame pulses.
        pulse_frames(100);
        issue(3, 0, 96, "static_tri");

        anim_en = 1'b1;
        pulse_frames(15);
        issue(3, 0, 128, "tri_ph1");
        pulse_frames(15);
        issue(8, 0, 320, "circ_ph2");
        issue(3, 0, 160, "tri_ph2");
        issue(5, 9, 169, "explicit_rot");
        pulse_frames(45);
        issue(3, 0, 96, "tri_wrap");

        // Invalid out-of-range code must not raise err.
        anim_en = 1'b0;
        tile_type = 7'd120; row = 5'd4; valid_in = 1'b0;
        tick();
        tick();
        check_eq("oor_invalid_err", err, 0);
`ifdef TILE_ROM_ADDR_ERR_EN
        issue(120, 4, 0, "oor_addr");
        check_eq("oor_err", err, 1);
        tick();
        tick();
        check_eq("oor_err_sticky", err, 1);
`else
        issue(120, 4, 3844, "oor_addr");
        check_eq("oor_err", err, 0);
`endif

        // Random stream with one asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            anim_en     = ($urandom_range(0, 15) != 0);
            frame_start = ($urandom_range(0, 2) == 0);
            valid_in    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: tile_type = 7'd3;
                1: tile_type = 7'd8;
                default: tile_type = 7'($urandom_range(0, 127));
            endcase
            row = 5'($urandom_range(0, 31));
            tick();
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("async_rst_valid", valid_out, 0);
                check_eq("async_rst_addr", addr, 0);
                check_eq("async_rst_err", err, 0);
                model_reset();
                tick();
                rst_n = 1'b1;
                anim_en = 1'b1;
                pulse_frames(14);
                issue(3, 1, 97, "post_rst_phase0");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
